// File: rtl/seq_detect_pkg.sv
// Shared types and default sizing for the programmable serial sequence detector.
package seq_detect_pkg;

    localparam int PAT_MAX_DEF = 8;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

endpackage

// File: rtl/seq_match_cmp.sv
// Masked compare of the history window against the programmed pattern.
// Only the low len bits take part; anything above the active length is ignored.
module seq_match_cmp #(
    parameter int PAT_MAX = 8,
    parameter int LEN_W   = $clog2(PAT_MAX + 1)
) (
    input  logic [PAT_MAX-1:0] hist,
    input  logic [PAT_MAX-1:0] pat,
    input  logic [LEN_W-1:0]   len,
    output logic               eq
);

    logic [PAT_MAX-1:0] mask;

    // Build the length mask and reduce the masked difference
    always_comb begin
        for (int i = 0; i < PAT_MAX; i++) begin
            mask[i] = (i < int'(len));
        end
        eq = ~|((hist ^ pat) & mask);
    end

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial sequence detector with overlap control.
// Optional match counter: define SEQ_DETECT_CNT_EN to add the match_cnt port.
// The bit that moves IDLE->FILL is itself consumed, so a stream can start on
// the same cycle en rises.
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter int PAT_MAX = PAT_MAX_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         din,
    input  logic                         din_vld,
    input  logic [PAT_MAX-1:0]           cfg_pat,
    input  logic [$clog2(PAT_MAX+1)-1:0] cfg_len,
    input  logic                         cfg_ovl,
    output logic                         flag,
    output logic                         cfg_err
`ifdef SEQ_DETECT_CNT_EN
    ,
    output logic [CNT_W-1:0]             match_cnt
`endif
);

    localparam int LEN_W = $clog2(PAT_MAX + 1);

    if (PAT_MAX < 2 || PAT_MAX > 32 || CNT_W < 1) begin : g_param_chk
        $error("seq_detect_prog: PAT_MAX must be 2..32 and CNT_W >= 1");
    end

    state_t             state;
    logic [PAT_MAX-1:0] hist;
    logic [PAT_MAX-1:0] hist_nxt;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_nxt;
    logic               cfg_bad;
    logic               run;
    logic               hit;
    logic               cmp_eq;

    // Next-state view of history/fill and the match decision for this edge
    always_comb begin
        cfg_bad  = (cfg_len == '0) || (cfg_len > LEN_W'(PAT_MAX));
        run      = en && !cfg_bad;
        hist_nxt = {hist[PAT_MAX-2:0], din};
        fill_nxt = (fill == LEN_W'(PAT_MAX)) ? fill : fill + LEN_W'(1);
        hit      = run && din_vld && (fill_nxt >= cfg_len) && cmp_eq;
    end

    seq_match_cmp #(
        .PAT_MAX (PAT_MAX),
        .LEN_W   (LEN_W)
    ) u_cmp (
        .hist (hist_nxt),
        .pat  (cfg_pat),
        .len  (cfg_len),
        .eq   (cmp_eq)
    );

    // Detector FSM: history shift, fill tracking, registered flag and cfg_err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            hist    <= '0;
            fill    <= '0;
            flag    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_bad;
            flag    <= hit;
            if (!run) begin
                // en low or bad length: drop everything, en wins over a match
                state <= IDLE;
                hist  <= '0;
                fill  <= '0;
            end else if (din_vld) begin
                hist <= hist_nxt;
                if (hit && !cfg_ovl) begin
                    // completing bit is not reused in non-overlap mode
                    fill  <= '0;
                    state <= FILL;
                end else begin
                    fill  <= fill_nxt;
                    state <= (fill_nxt >= cfg_len) ? ARMED : FILL;
                end
            end else if (state == IDLE) begin
                state <= FILL;
            end
        end
    end

`ifdef SEQ_DETECT_CNT_EN
    // Saturating match counter, stepped on the same edge that raises flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt <= '0;
        end else if (hit && (match_cnt != {CNT_W{1'b1}})) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: directed scenarios plus randomized bursts checked
// against a queue-based model of the consumed bit stream.
module tb_seq_detect_prog;

    localparam int PAT_MAX = 8;
    localparam int LEN_W   = $clog2(PAT_MAX + 1);
    localparam int CNT_W   = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic               din = 1'b0;
    logic               din_vld = 1'b0;
    logic               cfg_ovl = 1'b0;
    logic [PAT_MAX-1:0] cfg_pat = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               flag;
    logic               cfg_err;
`ifdef SEQ_DETECT_CNT_EN
    logic [CNT_W-1:0]   match_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    // reference model state: bits consumed since the last clear
    bit q[$];
    logic exp_flag = 1'b0;
    logic exp_err = 1'b0;
    int   exp_cnt = 0;

    seq_detect_prog #(.PAT_MAX(PAT_MAX), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .din       (din),
        .din_vld   (din_vld),
        .cfg_pat   (cfg_pat),
        .cfg_len   (cfg_len),
        .cfg_ovl   (cfg_ovl),
        .flag      (flag),
        .cfg_err   (cfg_err)
`ifdef SEQ_DETECT_CNT_EN
        ,
        .match_cnt (match_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        q.delete();
        exp_flag = 1'b0;
        exp_err  = 1'b0;
        exp_cnt  = 0;
    endtask

    // drive one cycle of inputs, advance the model, land 1 time unit after the edge
    task automatic step(input logic e, input logic d, input logic v);
        bit bad;
        bit m;
        int n;
        en = e; din = d; din_vld = v;
        bad = (cfg_len == 0) || (int'(cfg_len) > PAT_MAX);
        m = 1'b0;
        if (!e || bad) begin
            q.delete();
        end else if (v) begin
            q.push_back(d);
            if (q.size() > PAT_MAX) void'(q.pop_front());
            n = q.size();
            if (n >= int'(cfg_len)) begin
                m = 1'b1;
                for (int k = 0; k < int'(cfg_len); k++)
                    if (q[n-1-k] != cfg_pat[k]) m = 1'b0;
            end
            if (m && !cfg_ovl) q.delete();
        end
        exp_flag = m;
        exp_err  = bad;
        if (m && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    // asynchronous reset pulse placed between clock edges
    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        cfg_len = '0;
        en = 1'b1;
        #3;
        vectors++;
        if (flag !== 1'b0 || cfg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs flag=%b cfg_err=%b want 0/0", flag, cfg_err);
        end
`ifdef SEQ_DETECT_CNT_EN
        vectors++;
        if (match_cnt !== '0) begin
            miscompares++;
            $display("FAIL reset_cnt got %0d want 0", match_cnt);
        end
`endif
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (cfg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold cfg_err=%b want 0", cfg_err);
        end
        en = 1'b0;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic run_1101(input logic ovl, input logic [6:0] want_pos, input int want_cnt, input string name);
        logic [6:0] bits;
        logic [6:0] pos;
        bits = 7'b1101101;
        pos  = '0;
        cfg_pat = 8'b0000_1101; cfg_len = 4'd4; cfg_ovl = ovl;
        pulse_reset();
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, bits[6-i], 1'b1);
            pos[i] = flag;
            vectors++;
            if (flag !== exp_flag) begin
                miscompares++;
                $display("FAIL %s bit%0d flag got %b want %b", name, i + 1, flag, exp_flag);
            end
        end
        vectors++;
        if (pos !== want_pos) begin
            miscompares++;
            $display("FAIL %s positions got %b want %b", name, pos, want_pos);
        end
`ifdef SEQ_DETECT_CNT_EN
        vectors++;
        if (int'(match_cnt) !== want_cnt) begin
            miscompares++;
            $display("FAIL %s cnt got %0d want %0d", name, match_cnt, want_cnt);
        end
`else
        if (want_cnt < 0) $display("note: negative count request ignored");
`endif
    endtask

    task automatic test_overlap();
        run_1101(1'b1, 7'b1001000, 2, "overlap");
    endtask

    task automatic test_non_overlap();
        run_1101(1'b0, 7'b0001000, 1, "non_overlap");
    endtask

    task automatic test_gaps();
        logic [7:0] p;
        int nf;
        int at;
        int idx;
        p = 8'hA5; nf = 0; at = -1; idx = 0;
        cfg_pat = p; cfg_len = 4'd8; cfg_ovl = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, p[7-i], 1'b1);
            if (flag) begin nf++; at = idx; end
            idx++;
            for (int g = 0; g < 3; g++) begin
                step(1'b1, 1'b1, 1'b0);
                if (flag) begin nf++; at = idx; end
                idx++;
            end
        end
        vectors++;
        if (nf !== 1 || at !== 28) begin
            miscompares++;
            $display("FAIL gaps flags=%0d at step %0d want 1 at step 28", nf, at);
        end
    endtask

    task automatic test_cfg_err();
        logic [LEN_W-1:0] lens[2];
        lens[0] = 4'd0; lens[1] = 4'd9;
        for (int l = 0; l < 2; l++) begin
            cfg_len = lens[l]; cfg_pat = 8'hFF; cfg_ovl = 1'b1;
            for (int i = 0; i < 12; i++) begin
                step(1'b1, 1'b1, 1'b1);
                vectors++;
                if (flag !== 1'b0 || cfg_err !== 1'b1) begin
                    miscompares++;
                    $display("FAIL cfg_err len=%0d flag=%b cfg_err=%b want 0/1", lens[l], flag, cfg_err);
                end
            end
        end
        cfg_len = 4'd4;
        step(1'b0, 1'b0, 1'b0);
        vectors++;
        if (cfg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL cfg_err_clear got %b want 0", cfg_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] p;
        logic [3:0] pos;
        p = 4'b1101; pos = '0;
        cfg_pat = 8'b0000_1101; cfg_len = 4'd4; cfg_ovl = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, p[3-i], 1'b1);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (flag !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid async flag got %b want 0", flag);
        end
        #1;
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, p[3-i], 1'b1);
            pos[i] = flag;
        end
        vectors++;
        if (pos !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_mid positions got %b want 1000", pos);
        end
    endtask

    task automatic test_saturate();
        int want[5];
        int nf;
        want = '{1, 2, 3, 3, 3};
        nf = 0;
        cfg_pat = 8'b0000_0011; cfg_len = 4'd2; cfg_ovl = 1'b1;
        pulse_reset();
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b1);
            if (flag) begin
`ifdef SEQ_DETECT_CNT_EN
                vectors++;
                if (nf < 5 && int'(match_cnt) !== want[nf]) begin
                    miscompares++;
                    $display("FAIL saturate match %0d cnt got %0d want %0d", nf + 1, match_cnt, want[nf]);
                end
`endif
                nf++;
            end
        end
        vectors++;
        if (nf !== 5) begin
            miscompares++;
            $display("FAIL saturate flags got %0d want 5", nf);
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 40; b++) begin
            cfg_len = ($urandom_range(0, 9) == 0) ? LEN_W'($urandom_range(9, 15))
                                                 : LEN_W'($urandom_range(1, 4));
            cfg_pat = PAT_MAX'($urandom);
            cfg_ovl = 1'($urandom);
            step(1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 50; i++) begin
                step(($urandom_range(0, 24) != 0), 1'($urandom), ($urandom_range(0, 3) != 0));
                vectors++;
                if (flag !== exp_flag || cfg_err !== exp_err) begin
                    miscompares++;
                    $display("FAIL random burst%0d step%0d flag=%b/%b cfg_err=%b/%b (got/want)",
                             b, i, flag, exp_flag, cfg_err, exp_err);
                end
`ifdef SEQ_DETECT_CNT_EN
                vectors++;
                if (int'(match_cnt) !== exp_cnt) begin
                    miscompares++;
                    $display("FAIL random_cnt got %0d want %0d", match_cnt, exp_cnt);
                end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_gaps();
        test_cfg_err();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
